dmem_responder: RTL and testbench

Data-memory responder that serves the core's load/store traffic. It sits on the memory side of the core's data interface: the core drives read and write requests, and this block owns the word array, commits stores, and returns load data after a fixed, parameterised latency. It replaces the core's ad-hoc combinational data memory with a handshaked, cycle-accurate responder.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 197 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder.
//                Defines the read FSM state type, the word and strobe
//                widths, the wait-counter width, and the address legality
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int unsigned STRB_W     = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rd_state_t;

    // An access is legal when it is word aligned and indexes inside the array
    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word RAM with one synchronous byte-strobed write port and
//                one asynchronous read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [WORD_W-1:0]              i_wdata,
    input  logic [STRB_W-1:0]              i_wstrb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output logic [WORD_W-1:0]              o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    // Commit only the strobed bytes of the addressed word
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Handshaked data-memory responder. Commits stores in zero
//                cycles and returns load data after 1+WAIT_CYCLES cycles.
//                Illegal (misaligned / out-of-range) accesses are flagged.
//                Optional macro DMEM_BYPASS_EN merges a store accepted on
//                the read-capture edge into the returned load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [WORD_W-1:0] read_address,
    output logic              rd_resp_valid,
    output logic [WORD_W-1:0] data_out,
    output logic              rd_err,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] write_address,
    input  logic [WORD_W-1:0] data_write,
    input  logic [STRB_W-1:0] write_strb,
    output logic              wr_err
);

    localparam int unsigned            c_addr_w    = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0]  c_wait_load = WAIT_CNT_W'(WAIT_CYCLES - 1);

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  w_rd_accept;
    logic                  w_capture;
    logic                  w_rd_req_legal;
    logic                  w_wr_legal;
    logic                  w_wr_commit;
    logic [c_addr_w-1:0]   w_rd_req_idx;
    logic [c_addr_w-1:0]   w_wr_idx;
    logic [c_addr_w-1:0]   w_cap_idx;
    logic                  w_cap_legal;
    logic [WORD_W-1:0]     w_arr_rdata;
    logic [WORD_W-1:0]     w_cap_word;

    assign w_rd_req_legal = addr_ok(read_address, 32'(DEPTH_WORDS));
    assign w_wr_legal     = addr_ok(write_address, 32'(DEPTH_WORDS));
    assign w_rd_req_idx   = read_address[c_addr_w+1:2];
    assign w_wr_idx       = write_address[c_addr_w+1:2];
    assign w_wr_commit    = wr_valid && w_wr_legal;
    assign w_rd_accept    = rd_valid && rd_ready;
    assign wr_ready       = 1'b1;

    // Read FSM state register; a reset discards any pending read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next state, handshake outputs and data-capture strobe
    always_comb begin
        w_state_nxt   = r_state;
        rd_ready      = 1'b1;
        rd_resp_valid = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = RESP;
                        w_capture   = 1'b1;
                    end
                end
            end
            WAIT: begin
                rd_ready = 1'b0;
                if (r_wait_cnt == '0) begin
                    w_state_nxt = RESP;
                    w_capture   = 1'b1;
                end
            end
            RESP: begin
                rd_resp_valid = 1'b1;
                if (w_rd_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = RESP;
                        w_capture   = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Wait-state down-counter, reloaded on every accepted read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (w_rd_accept) begin
            r_wait_cnt <= c_wait_load;
        end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
        end
    end

    // With no wait states the capture edge is the accept edge, so the live
    // request address is used; otherwise the address latched at accept.
    generate
        if (WAIT_CYCLES == 0) begin : g_no_wait
            assign w_cap_idx   = w_rd_req_idx;
            assign w_cap_legal = w_rd_req_legal;
        end else begin : g_wait
            logic [c_addr_w-1:0] r_rd_idx;
            logic                r_rd_legal;

            // Latch the request address and its legality at accept
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_rd_idx   <= '0;
                    r_rd_legal <= 1'b0;
                end else if (w_rd_accept) begin
                    r_rd_idx   <= w_rd_req_idx;
                    r_rd_legal <= w_rd_req_legal;
                end
            end

            assign w_cap_idx   = r_rd_idx;
            assign w_cap_legal = r_rd_legal;
        end
    endgenerate

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_wr_commit),
        .i_waddr (w_wr_idx),
        .i_wdata (data_write),
        .i_wstrb (write_strb),
        .i_raddr (w_cap_idx),
        .o_rdata (w_arr_rdata)
    );

`ifdef DMEM_BYPASS_EN
    // Forward strobed bytes of a same-edge store to the same word
    always_comb begin
        w_cap_word = w_arr_rdata;
        if (w_wr_commit && (w_wr_idx == w_cap_idx)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (write_strb[b]) begin
                    w_cap_word[8*b +: 8] = data_write[8*b +: 8];
                end
            end
        end
    end
`else
    assign w_cap_word = w_arr_rdata;
`endif

    // Response data register; holds its value between responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            rd_err   <= 1'b0;
        end else if (w_capture) begin
            data_out <= w_cap_legal ? w_cap_word : '0;
            rd_err   <= !w_cap_legal;
        end
    end

    // One-cycle pulse for a dropped store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_valid && !w_wr_legal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Two instances share
//                the write channel: one with no wait states, one with three.
//                A reference word model feeds per-instance expected queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int unsigned c_depth = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [31:0] write_address;
    logic [31:0] data_write;
    logic [3:0]  write_strb;

    logic        rd_valid0, rd_ready0, rd_resp_valid0, rd_err0, wr_ready0, wr_err0;
    logic [31:0] read_address0, data_out0;
    logic        rd_valid3, rd_ready3, rd_resp_valid3, rd_err3, wr_ready3, wr_err3;
    logic [31:0] read_address3, data_out3;

    int total = 0;
    int bad   = 0;

    logic [32:0] q0[$];
    logic [32:0] q3[$];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(c_depth), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid0), .rd_ready(rd_ready0), .read_address(read_address0),
        .rd_resp_valid(rd_resp_valid0), .data_out(data_out0), .rd_err(rd_err0),
        .wr_valid(wr_valid), .wr_ready(wr_ready0), .write_address(write_address),
        .data_write(data_write), .write_strb(write_strb), .wr_err(wr_err0)
    );

    dmem_responder #(.DEPTH_WORDS(c_depth), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid3), .rd_ready(rd_ready3), .read_address(read_address3),
        .rd_resp_valid(rd_resp_valid3), .data_out(data_out3), .rd_err(rd_err3),
        .wr_valid(wr_valid), .wr_ready(wr_ready3), .write_address(write_address),
        .data_write(data_write), .write_strb(write_strb), .wr_err(wr_err3)
    );

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < c_depth * 4);
    endfunction

    function automatic logic [32:0] exp_rd(input logic [31:0] a);
        if (!legal(a)) return {1'b1, 32'h0};
        if (ref_mem.exists(int'(a >> 2))) return {1'b0, ref_mem[int'(a >> 2)]};
        return {1'b0, 32'h0};
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!legal(a)) return;
        w = ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a >> 2)] = w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_valid = 1'b1; write_address = a; data_write = d; write_strb = s;
        model_wr(a, d, s);
        tick();
        wr_valid = 1'b0;
        total++;
        if ({wr_err0, wr_err3} !== {2{~legal(a)}}) begin
            bad++;
            $display("FAIL write_err addr=%h got=%b exp=%b", a, {wr_err0, wr_err3}, {2{~legal(a)}});
        end
    endtask

    task automatic read0(input logic [31:0] a);
        logic [32:0] e;
        q0.push_back(exp_rd(a));
        rd_valid0 = 1'b1; read_address0 = a;
        tick();
        rd_valid0 = 1'b0;
        total++;
        if (rd_resp_valid0 !== 1'b1) begin
            bad++;
            $display("FAIL read0_valid addr=%h got=%b exp=1", a, rd_resp_valid0);
            void'(q0.pop_front());
        end else begin
            e = q0.pop_front();
            total++;
            if ({rd_err0, data_out0} !== e) begin
                bad++;
                $display("FAIL read0_data addr=%h got=%b/%h exp=%b/%h", a, rd_err0, data_out0, e[32], e[31:0]);
            end
            tick();
            total++;
            if (rd_resp_valid0 !== 1'b0 || {rd_err0, data_out0} !== e) begin
                bad++;
                $display("FAIL read0_hold addr=%h got=%b %b/%h exp=0 %b/%h", a, rd_resp_valid0, rd_err0, data_out0, e[32], e[31:0]);
            end
        end
    endtask

    task automatic read3(input logic [31:0] a);
        logic [32:0] e;
        int lat;
        q3.push_back(exp_rd(a));
        rd_valid3 = 1'b1; read_address3 = a;
        tick();
        rd_valid3 = 1'b0;
        lat = 1;
        while (rd_resp_valid3 !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL read3_latency addr=%h got=%0d exp=4", a, lat);
        end
        e = q3.pop_front();
        total++;
        if ({rd_err3, data_out3} !== e) begin
            bad++;
            $display("FAIL read3_data addr=%h got=%b/%h exp=%b/%h", a, rd_err3, data_out3, e[32], e[31:0]);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_valid = 1'b0; write_address = '0; data_write = '0; write_strb = '0;
        rd_valid0 = 1'b0; read_address0 = '0; rd_valid3 = 1'b0; read_address3 = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total++;
        if (rd_ready0 !== 1'b1 || rd_ready3 !== 1'b1) begin
            bad++; $display("FAIL reset_rd_ready got=%b%b exp=11", rd_ready0, rd_ready3);
        end
        total++;
        if (rd_resp_valid0 !== 1'b0 || rd_resp_valid3 !== 1'b0) begin
            bad++; $display("FAIL reset_resp_valid got=%b%b exp=00", rd_resp_valid0, rd_resp_valid3);
        end
        total++;
        if (data_out0 !== 32'h0 || data_out3 !== 32'h0) begin
            bad++; $display("FAIL reset_data_out got=%h %h exp=0", data_out0, data_out3);
        end
        total++;
        if (rd_err0 !== 1'b0 || rd_err3 !== 1'b0) begin
            bad++; $display("FAIL reset_rd_err got=%b%b exp=00", rd_err0, rd_err3);
        end
        total++;
        if (wr_err0 !== 1'b0 || wr_err3 !== 1'b0) begin
            bad++; $display("FAIL reset_wr_err got=%b%b exp=00", wr_err0, wr_err3);
        end
        total++;
        if (wr_ready0 !== 1'b1 || wr_ready3 !== 1'b1) begin
            bad++; $display("FAIL reset_wr_ready got=%b%b exp=11", wr_ready0, wr_ready3);
        end
    endtask

    task automatic test_basic();
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        read0(32'h10);
    endtask

    task automatic test_strobe();
        do_write(32'h20, 32'hAABBCCDD, 4'hF);
        do_write(32'h20, 32'h11223344, 4'h5);
        read0(32'h20);
        do_write(32'h20, 32'hFFFFFFFF, 4'h0);
        read0(32'h20);
    endtask

    task automatic test_errors();
        read0(32'h13);
        read0(c_depth * 4);
        do_write(32'h13, 32'hFFFFFFFF, 4'hF);
        tick();
        total++;
        if (wr_err0 !== 1'b0 || wr_err3 !== 1'b0) begin
            bad++; $display("FAIL wr_err_pulse got=%b%b exp=00", wr_err0, wr_err3);
        end
        do_write(c_depth * 4, 32'h12121212, 4'hF);
        read0(32'h10);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [32:0] e;
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h13;
        rd_valid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            read_address0 = addrs[i];
            q0.push_back(exp_rd(addrs[i]));
            tick();
            e = q0.pop_front();
            total++;
            if (rd_resp_valid0 !== 1'b1 || {rd_err0, data_out0} !== e) begin
                bad++;
                $display("FAIL b2b_resp%0d got=%b %b/%h exp=1 %b/%h", i, rd_resp_valid0, rd_err0, data_out0, e[32], e[31:0]);
            end
        end
        rd_valid0 = 1'b0;
        tick();
        total++;
        if (rd_resp_valid0 !== 1'b0) begin
            bad++; $display("FAIL b2b_idle got=%b exp=0", rd_resp_valid0);
        end
    endtask

    task automatic test_wait_states();
        logic [32:0] e;
        int lat;
        q3.push_back(exp_rd(32'h10));
        rd_valid3 = 1'b1; read_address3 = 32'h10;
        tick();
        read_address3 = 32'h20;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_ready3 !== 1'b0 || rd_resp_valid3 !== 1'b0) begin
                bad++; $display("FAIL wait_cycle%0d got=rdy%b vld%b exp=rdy0 vld0", i, rd_ready3, rd_resp_valid3);
            end
            tick();
        end
        e = q3.pop_front();
        total++;
        if (rd_resp_valid3 !== 1'b1 || rd_ready3 !== 1'b1 || {rd_err3, data_out3} !== e) begin
            bad++;
            $display("FAIL wait_resp1 got=vld%b rdy%b %b/%h exp=vld1 rdy1 %b/%h", rd_resp_valid3, rd_ready3, rd_err3, data_out3, e[32], e[31:0]);
        end
        q3.push_back(exp_rd(32'h20));
        tick();
        rd_valid3 = 1'b0;
        lat = 1;
        while (rd_resp_valid3 !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        e = q3.pop_front();
        total++;
        if (lat != 4 || {rd_err3, data_out3} !== e) begin
            bad++;
            $display("FAIL wait_resp2 got=lat%0d %b/%h exp=lat4 %b/%h", lat, rd_err3, data_out3, e[32], e[31:0]);
        end
        tick();
        total++;
        if (rd_resp_valid3 !== 1'b0) begin
            bad++; $display("FAIL wait_single got=%b exp=0", rd_resp_valid3);
        end
    endtask

    task automatic test_bypass();
        logic [32:0] e;
        do_write(32'h40, 32'h12345678, 4'hF);
        // Store and zero-wait read capture on the same edge
        wr_valid = 1'b1; write_address = 32'h40; data_write = 32'h00000055; write_strb = 4'h1;
        rd_valid0 = 1'b1; read_address0 = 32'h40;
`ifdef DMEM_BYPASS_EN
        q0.push_back({1'b0, 32'h12345655});
`else
        q0.push_back({1'b0, 32'h12345678});
`endif
        model_wr(32'h40, 32'h00000055, 4'h1);
        tick();
        wr_valid = 1'b0; rd_valid0 = 1'b0;
        e = q0.pop_front();
        total++;
        if (rd_resp_valid0 !== 1'b1 || {rd_err0, data_out0} !== e) begin
            bad++; $display("FAIL bypass0 got=%b %b/%h exp=1 %b/%h", rd_resp_valid0, rd_err0, data_out0, e[32], e[31:0]);
        end
        read0(32'h40);
        // Store on the wait-exit capture edge of the three-wait instance
        rd_valid3 = 1'b1; read_address3 = 32'h40;
        tick();
        rd_valid3 = 1'b0;
        tick();
        tick();
        wr_valid = 1'b1; write_address = 32'h40; data_write = 32'h00AA0000; write_strb = 4'h4;
`ifdef DMEM_BYPASS_EN
        q3.push_back({1'b0, 32'h12AA5655});
`else
        q3.push_back({1'b0, 32'h12345655});
`endif
        model_wr(32'h40, 32'h00AA0000, 4'h4);
        tick();
        wr_valid = 1'b0;
        e = q3.pop_front();
        total++;
        if (rd_resp_valid3 !== 1'b1 || {rd_err3, data_out3} !== e) begin
            bad++; $display("FAIL bypass3 got=%b %b/%h exp=1 %b/%h", rd_resp_valid3, rd_err3, data_out3, e[32], e[31:0]);
        end
        tick();
        read3(32'h40);
        read0(32'h40);
    endtask

    task automatic test_reset_mid();
        bit seen;
        rd_valid3 = 1'b1; read_address3 = 32'h10;
        tick();
        rd_valid3 = 1'b0;
        tick();
        reset = 1'b0;
        #2;
        total++;
        if (rd_ready3 !== 1'b1) begin
            bad++; $display("FAIL midreset_async_ready got=%b exp=1", rd_ready3);
        end
        tick();
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rd_resp_valid3 === 1'b1) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL midreset_no_resp got=1 exp=0");
        end
        total++;
        if (rd_ready3 !== 1'b1 || rd_err3 !== 1'b0 || data_out3 !== 32'h0) begin
            bad++; $display("FAIL midreset_idle got=rdy%b err%b %h exp=rdy1 err0 0", rd_ready3, rd_err3, data_out3);
        end
        read3(32'h20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_wait_states();
        test_bypass();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
